// File: rtl/sd_pkg.sv
// Shared SD host definitions: command/response field layout, response types,
// scheduler status codes and the command index set.
package sd_pkg;

    localparam int CMD_W  = 38;
    localparam int RESP_W = 127;

    localparam int CMD_IDX_MSB  = 37;
    localparam int CMD_IDX_LSB  = 32;
    localparam int CMD_ARG_MSB  = 31;
    localparam int CMD_ARG_LSB  = 0;
    localparam int RESP_IDX_MSB = 125;
    localparam int RESP_IDX_LSB = 120;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R1   = 2'd1,
        RESP_R3   = 2'd2,
        RESP_R2   = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_CRC_ERR   = 3'd1,
        ST_TIMEOUT   = 3'd2,
        ST_INDEX_ERR = 3'd3,
        ST_ABORT     = 3'd4
    } sd_status_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_TX   = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_GAP       = 3'd4
    } sched_state_e;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD9   = 6'd9;
    localparam logic [5:0] CMD12  = 6'd12;
    localparam logic [5:0] CMD13  = 6'd13;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD18  = 6'd18;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD25  = 6'd25;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD56  = 6'd56;
    localparam logic [5:0] ACMD6  = 6'd6;
    localparam logic [5:0] ACMD13 = 6'd13;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] ACMD51 = 6'd51;

    // R1 and R2 carry a CRC worth checking; R3 has all-ones in the CRC field.
    function automatic logic resp_has_crc(input resp_type_e t);
        return (t == RESP_R1) || (t == RESP_R2);
    endfunction

    function automatic logic resp_has_index(input resp_type_e t);
        return t == RESP_R1;
    endfunction

endpackage

// File: rtl/sd_cmd_scheduler_if.sv
// Requester and serializer/deserializer signals around the CMD-line scheduler.
interface sd_cmd_scheduler_if;
    import sd_pkg::*;

    logic [1:0]         req;
    logic [2*CMD_W-1:0] req_content;
    logic [3:0]         req_resp_type;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic [2:0]         status;
    logic [RESP_W-1:0]  resp_data;
    logic               send_en;
    logic [CMD_W-1:0]   send_cmd_content;
    logic               R2_response;
    logic               receive_en;
    logic               sd_cmd_sending;
    logic               sd_receive_finished;
    logic               crc_response_err;
    logic [RESP_W-1:0]  response;

    modport slave (
        input  req, req_content, req_resp_type,
        input  sd_cmd_sending, sd_receive_finished, crc_response_err, response,
        output gnt, done, status, resp_data,
        output send_en, send_cmd_content, R2_response, receive_en
    );

    modport master (
        output req, req_content, req_resp_type,
        output sd_cmd_sending, sd_receive_finished, crc_response_err, response,
        input  gnt, done, status, resp_data,
        input  send_en, send_cmd_content, R2_response, receive_en
    );

endinterface

// File: rtl/sd_rr_arbiter.sv
// Two-way round-robin arbiter; lock freezes both the grant and the pointer
// while a command is in flight.
module sd_rr_arbiter (
    input  logic       ex_clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] grant
);

    // Index of the requester granted last; reset to 1 so requester 0 wins first.
    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (!lock) begin
            if (req == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant[0]) begin
            last_q <= 1'b0;
        end else if (grant[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/sd_cmd_scheduler.sv
// Shares the SD CMD line between the card FSM and the UART debug path: arbitration,
// response tracking with NCR timeout, CRC retry and N_CC gap enforcement.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no owner; arbitrate and latch the winning command
// SEND      | one-cycle send_en pulse to the serializer
// WAIT_TX   | serializer shifting the command out
// WAIT_RESP | response window, NCR timeout counting down
// GAP       | N_CC idle time, then SEND (retry pending) or IDLE
module sd_cmd_scheduler
    import sd_pkg::*;
#(
    parameter int NCR_CYCLES = 8000,
    parameter int GAP_CYCLES = 1000,
    parameter int MAX_RETRY  = 2,
    parameter int CNT_W      = 16
) (
    input  logic              ex_clk,
    input  logic              reset_n,
    input  logic              software_reset,
    sd_cmd_scheduler_if.slave bus
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0]   NCR_LOAD  = CNT_W'(NCR_CYCLES);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pend_q, pend_d;
    logic               tx_seen_q, tx_seen_d;
    logic [1:0]         owner_q, owner_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    resp_type_e         type_q, type_d;
    logic [RESP_W-1:0]  resp_q, resp_d;
    sd_status_e         status_q, status_d;
    logic               done_q, done_d;

    logic [1:0]         arb_grant;
    logic               arb_lock;
    logic               cnt_expire;
    logic               idx_match;

    assign arb_lock   = (state_q != S_IDLE);
    // A down-counter at 1 reaches terminal count on this edge.
    assign cnt_expire = (cnt_q <= CNT_ONE);
    assign idx_match  = (bus.response[RESP_IDX_MSB:RESP_IDX_LSB] ==
                         cmd_q[CMD_IDX_MSB:CMD_IDX_LSB]);

    sd_rr_arbiter u_arb (
        .ex_clk  (ex_clk),
        .reset_n (reset_n),
        .req     (bus.req),
        .lock    (arb_lock),
        .grant   (arb_grant)
    );

    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            pend_q    <= 1'b0;
            tx_seen_q <= 1'b0;
            owner_q   <= 2'b00;
            cmd_q     <= '0;
            type_q    <= RESP_NONE;
            resp_q    <= '0;
            status_q  <= ST_OK;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pend_q    <= pend_d;
            tx_seen_q <= tx_seen_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            type_q    <= type_d;
            resp_q    <= resp_d;
            status_q  <= status_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        pend_d    = pend_q;
        tx_seen_d = tx_seen_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        type_d    = type_q;
        resp_d    = resp_q;
        status_d  = status_q;
        done_d    = 1'b0;

        if (software_reset && (state_q != S_IDLE)) begin
            state_d  = S_GAP;
            cnt_d    = GAP_LOAD;
            pend_d   = 1'b0;
            done_d   = 1'b1;
            status_d = ST_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_grant != 2'b00) begin
                        owner_d = arb_grant;
                        cmd_d   = arb_grant[1] ? bus.req_content[2*CMD_W-1:CMD_W]
                                               : bus.req_content[CMD_W-1:0];
                        type_d  = resp_type_e'(arb_grant[1] ? bus.req_resp_type[3:2]
                                                            : bus.req_resp_type[1:0]);
                        retry_d = '0;
                        pend_d  = 1'b0;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    tx_seen_d = 1'b0;
                    state_d   = S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.sd_cmd_sending) begin
                        tx_seen_d = 1'b1;
                    end else if (tx_seen_q) begin
                        if (type_q == RESP_NONE) begin
                            state_d  = S_GAP;
                            cnt_d    = GAP_LOAD;
                            done_d   = 1'b1;
                            status_d = ST_OK;
                        end else begin
                            state_d = S_WAIT_RESP;
                            cnt_d   = NCR_LOAD;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    // A finish on the terminal-count cycle still counts as a response.
                    if (bus.sd_receive_finished) begin
                        resp_d  = bus.response;
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                        if (bus.crc_response_err && resp_has_crc(type_q)) begin
                            if (retry_q < RETRY_MAX) begin
                                retry_d = retry_q + RETRY_W'(1);
                                pend_d  = 1'b1;
                            end else begin
                                done_d   = 1'b1;
                                status_d = ST_CRC_ERR;
                            end
                        end else if (resp_has_index(type_q) && !idx_match) begin
                            done_d   = 1'b1;
                            status_d = ST_INDEX_ERR;
                        end else begin
                            done_d   = 1'b1;
                            status_d = ST_OK;
                        end
                    end else if (cnt_expire) begin
                        state_d  = S_GAP;
                        cnt_d    = GAP_LOAD;
                        done_d   = 1'b1;
                        status_d = ST_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_expire) begin
                        pend_d = 1'b0;
                        if (pend_q) begin
                            state_d = S_SEND;
                        end else begin
                            state_d = S_IDLE;
                            owner_d = 2'b00;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    owner_d = 2'b00;
                end
            endcase
        end
    end

    assign bus.gnt              = owner_q;
    assign bus.done             = done_q ? owner_q : 2'b00;
    assign bus.status           = status_q;
    assign bus.resp_data        = resp_q;
    assign bus.send_en          = (state_q == S_SEND) && !software_reset;
    assign bus.send_cmd_content = cmd_q;
    assign bus.R2_response      = (owner_q != 2'b00) && (type_q == RESP_R2);
    assign bus.receive_en       = (state_q == S_WAIT_RESP);

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// Directed bench for sd_cmd_scheduler: a vector table of single transactions plus
// hand-written retry, timeout, abort, reset and round-robin sequences.
module tb_sd_cmd_scheduler;
    import sd_pkg::*;

    localparam int NCR_CYCLES = 8000;
    localparam int GAP_CYCLES = 1000;
    localparam int MAX_RETRY  = 2;
    localparam int NVEC       = 7;

    typedef struct {
        logic [1:0]  req;
        logic [37:0] c0;
        logic [37:0] c1;
        logic [1:0]  t0;
        logic [1:0]  t1;
        logic [5:0]  resp_idx;
        logic        crc;
        logic [1:0]  exp_gnt;
        logic [37:0] exp_cmd;
        logic [2:0]  exp_status;
        logic        exp_r2;
    } vec_t;

    logic ex_clk;
    logic reset_n;
    logic software_reset;
    int   checks;
    int   failures;

    sd_cmd_scheduler_if bus ();

    sd_cmd_scheduler #(
        .NCR_CYCLES (NCR_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .MAX_RETRY  (MAX_RETRY),
        .CNT_W      (16)
    ) dut (
        .ex_clk         (ex_clk),
        .reset_n        (reset_n),
        .software_reset (software_reset),
        .bus            (bus)
    );

    initial ex_clk = 1'b0;
    always #5 ex_clk = ~ex_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ex_clk);
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return bus.send_en;
            1:       return bus.receive_en;
            2:       return bus.done != 2'b00;
            3:       return bus.gnt == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int max, output int cyc);
        cyc = 0;
        while (!probe(which) && cyc < max) begin
            tick();
            cyc++;
        end
        check(name, 128'(probe(which)), 128'(1));
    endtask

    task automatic tx(input int len);
        tick();
        bus.sd_cmd_sending = 1'b1;
        repeat (len) tick();
        bus.sd_cmd_sending = 1'b0;
    endtask

    task automatic respond(input logic [126:0] r, input logic crc);
        bus.response            = r;
        bus.crc_response_err    = crc;
        bus.sd_receive_finished = 1'b1;
        tick();
        bus.sd_receive_finished = 1'b0;
        bus.crc_response_err    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [126:0] rsp;
        logic [1:0]   own_t;
        int           cyc;
        bus.req_content   = {v.c1, v.c0};
        bus.req_resp_type = {v.t1, v.t0};
        bus.req           = v.req;
        tick();
        check("vec_send_en", 128'(bus.send_en), 128'(1));
        check("vec_gnt", 128'(bus.gnt), 128'(v.exp_gnt));
        check("vec_cmd", 128'(bus.send_cmd_content), 128'(v.exp_cmd));
        check("vec_r2", 128'(bus.R2_response), 128'(v.exp_r2));
        tick();
        check("vec_send_pulse", 128'(bus.send_en), 128'(0));
        tx(40);
        own_t = v.exp_gnt[1] ? v.t1 : v.t0;
        rsp   = {1'b0, v.resp_idx, 88'hC0FFEE, v.exp_cmd[31:0]};
        if (own_t != 2'd0) begin
            wait_for("vec_recv_en", 1, 10, cyc);
            repeat (10) tick();
            respond(rsp, v.crc);
        end else begin
            tick();
        end
        check("vec_done", 128'(bus.done), 128'(v.exp_gnt));
        check("vec_status", 128'(bus.status), 128'(v.exp_status));
        if (own_t != 2'd0 && (v.exp_status == ST_OK || v.exp_status == ST_CRC_ERR))
            check("vec_resp_data", 128'(bus.resp_data), 128'(rsp));
        bus.req = 2'b00;
        tick();
        check("vec_done_pulse", 128'(bus.done), 128'(0));
        wait_for("vec_gnt_drop", 3, GAP_CYCLES + 10, cyc);
        check("vec_gap_len", 128'(cyc + 1), 128'(GAP_CYCLES));
    endtask

    vec_t         vecs[NVEC];
    logic [126:0] rsp;
    int           cyc;
    int           sends;

    initial begin
        checks                  = 0;
        failures                = 0;
        reset_n                 = 1'b0;
        software_reset          = 1'b0;
        bus.req                 = 2'b00;
        bus.req_content         = '0;
        bus.req_resp_type       = '0;
        bus.sd_cmd_sending      = 1'b0;
        bus.sd_receive_finished = 1'b0;
        bus.crc_response_err    = 1'b0;
        bus.response            = '0;

        vecs[0] = '{req: 2'b01, c0: {CMD0, 32'h0}, c1: {CMD13, 32'hFFFF_FFFF},
                    t0: RESP_NONE, t1: RESP_R1, resp_idx: 6'd0, crc: 1'b0,
                    exp_gnt: 2'b01, exp_cmd: {CMD0, 32'h0}, exp_status: ST_OK, exp_r2: 1'b0};
        vecs[1] = '{req: 2'b11, c0: {CMD8, 32'h0000_01AA}, c1: {CMD13, 32'h1234_0000},
                    t0: RESP_R1, t1: RESP_R1, resp_idx: CMD13, crc: 1'b0,
                    exp_gnt: 2'b10, exp_cmd: {CMD13, 32'h1234_0000}, exp_status: ST_OK, exp_r2: 1'b0};
        vecs[2] = '{req: 2'b11, c0: {CMD8, 32'h0000_01AA}, c1: {CMD13, 32'h1234_0000},
                    t0: RESP_R1, t1: RESP_R1, resp_idx: CMD8, crc: 1'b0,
                    exp_gnt: 2'b01, exp_cmd: {CMD8, 32'h0000_01AA}, exp_status: ST_OK, exp_r2: 1'b0};
        vecs[3] = '{req: 2'b10, c0: {CMD17, 32'h0000_0400}, c1: {CMD55, 32'h0},
                    t0: RESP_R1, t1: RESP_R1, resp_idx: CMD55, crc: 1'b0,
                    exp_gnt: 2'b10, exp_cmd: {CMD55, 32'h0}, exp_status: ST_OK, exp_r2: 1'b0};
        vecs[4] = '{req: 2'b10, c0: {CMD17, 32'h0000_0400}, c1: {CMD55, 32'hABCD_0000},
                    t0: RESP_R1, t1: RESP_R1, resp_idx: 6'd13, crc: 1'b0,
                    exp_gnt: 2'b10, exp_cmd: {CMD55, 32'hABCD_0000}, exp_status: ST_INDEX_ERR, exp_r2: 1'b0};
        vecs[5] = '{req: 2'b01, c0: {CMD2, 32'h0}, c1: {CMD55, 32'h0},
                    t0: RESP_R2, t1: RESP_R1, resp_idx: 6'h3F, crc: 1'b0,
                    exp_gnt: 2'b01, exp_cmd: {CMD2, 32'h0}, exp_status: ST_OK, exp_r2: 1'b1};
        vecs[6] = '{req: 2'b01, c0: {ACMD41, 32'h40FF_8000}, c1: {CMD55, 32'h0},
                    t0: RESP_R3, t1: RESP_R1, resp_idx: 6'h3F, crc: 1'b1,
                    exp_gnt: 2'b01, exp_cmd: {ACMD41, 32'h40FF_8000}, exp_status: ST_OK, exp_r2: 1'b0};

        repeat (3) tick();
        check("rst_outputs", 128'({bus.gnt, bus.done, bus.status, bus.send_en, bus.receive_en,
                                   bus.R2_response, bus.send_cmd_content}), 128'(0));
        check("rst_resp_data", 128'(bus.resp_data), 128'(0));
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // CRC error on every attempt: two resends, then one CRC_ERR completion.
        bus.req_content   = {{CMD13, 32'h0}, {CMD17, 32'h0000_0200}};
        bus.req_resp_type = {RESP_NONE, RESP_R1};
        bus.req           = 2'b01;
        sends             = 0;
        tick();
        for (int a = 0; a < 3; a++) begin
            if (a > 0) begin
                wait_for("crc_resend", 0, GAP_CYCLES + 20, cyc);
                check("crc_retry_gap", 128'(cyc), 128'(GAP_CYCLES));
            end
            if (bus.send_en) sends++;
            tx(40);
            wait_for("crc_recv_en", 1, 10, cyc);
            repeat (5) tick();
            rsp = {1'b0, CMD17, 88'(a), 32'h0000_0200};
            respond(rsp, 1'b1);
            if (a < 2) check("crc_no_done", 128'(bus.done), 128'(0));
        end
        check("crc_done", 128'(bus.done), 128'(2'b01));
        check("crc_status", 128'(bus.status), 128'(ST_CRC_ERR));
        check("crc_resp_data", 128'(bus.resp_data), 128'(rsp));
        bus.req = 2'b00;
        cyc = 0;
        while (bus.gnt != 2'b00 && cyc < GAP_CYCLES + 10) begin
            tick();
            cyc++;
            if (bus.send_en) sends++;
        end
        check("crc_gnt_drop", 128'(bus.gnt), 128'(0));
        check("crc_send_count", 128'(sends), 128'(3));

        // No response: timeout exactly NCR_CYCLES after entering the response window.
        bus.req_content   = {{CMD9, 32'h0001_0000}, {CMD0, 32'h0}};
        bus.req_resp_type = {RESP_R2, RESP_NONE};
        bus.req           = 2'b10;
        tick();
        check("to_send_en", 128'(bus.send_en), 128'(1));
        check("to_r2", 128'(bus.R2_response), 128'(1));
        tx(40);
        wait_for("to_recv_en", 1, 10, cyc);
        wait_for("to_done_seen", 2, NCR_CYCLES + 50, cyc);
        check("to_latency", 128'(cyc), 128'(NCR_CYCLES));
        check("to_done", 128'(bus.done), 128'(2'b10));
        check("to_status", 128'(bus.status), 128'(ST_TIMEOUT));
        bus.req = 2'b00;
        wait_for("to_gnt_drop", 3, GAP_CYCLES + 10, cyc);

        // software_reset while waiting for the response.
        bus.req_content   = {{CMD13, 32'h0}, {CMD7, 32'h1234_0000}};
        bus.req_resp_type = {RESP_R1, RESP_R1};
        bus.req           = 2'b01;
        tick();
        check("abr_send_en", 128'(bus.send_en), 128'(1));
        tx(40);
        wait_for("abr_recv_en", 1, 10, cyc);
        repeat (5) tick();
        software_reset = 1'b1;
        tick();
        software_reset = 1'b0;
        bus.req        = 2'b00;
        check("abr_done", 128'(bus.done), 128'(2'b01));
        check("abr_status", 128'(bus.status), 128'(ST_ABORT));
        check("abr_recv_off", 128'(bus.receive_en), 128'(0));
        wait_for("abr_gnt_drop", 3, GAP_CYCLES + 10, cyc);

        // software_reset in SEND suppresses the send_en pulse.
        bus.req = 2'b10;
        tick();
        check("abs_gnt", 128'(bus.gnt), 128'(2'b10));
        software_reset = 1'b1;
        #1;
        check("abs_send_suppressed", 128'(bus.send_en), 128'(0));
        tick();
        software_reset = 1'b0;
        bus.req        = 2'b00;
        check("abs_done", 128'(bus.done), 128'(2'b10));
        check("abs_status", 128'(bus.status), 128'(ST_ABORT));
        wait_for("abs_gnt_drop", 3, GAP_CYCLES + 10, cyc);

        // reset_n asserted while the command is being shifted out.
        bus.req_content   = {{CMD13, 32'h0}, {CMD8, 32'h0000_01AA}};
        bus.req_resp_type = {RESP_R1, RESP_R1};
        bus.req           = 2'b01;
        tick();
        check("rmid_send_en", 128'(bus.send_en), 128'(1));
        tick();
        bus.sd_cmd_sending = 1'b1;
        repeat (5) tick();
        check("rmid_gnt_before", 128'(bus.gnt), 128'(2'b01));
        reset_n = 1'b0;
        @(posedge ex_clk);
        #1;
        check("rmid_outputs", 128'({bus.gnt, bus.done, bus.status, bus.send_en, bus.receive_en,
                                    bus.R2_response, bus.send_cmd_content}), 128'(0));
        check("rmid_resp_data", 128'(bus.resp_data), 128'(0));
        bus.sd_cmd_sending = 1'b0;
        bus.req            = 2'b00;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Both requesters held: grants alternate 01, 10, 01 starting from reset.
        bus.req_content   = {{CMD55, 32'h0}, {CMD0, 32'h0}};
        bus.req_resp_type = {RESP_NONE, RESP_NONE};
        bus.req           = 2'b11;
        tick();
        check("rr_send0", 128'(bus.send_en), 128'(1));
        check("rr_gnt0", 128'(bus.gnt), 128'(2'b01));
        tx(10);
        tick();
        check("rr_done0", 128'(bus.done), 128'(2'b01));
        wait_for("rr_send1", 0, GAP_CYCLES + 20, cyc);
        check("rr_spacing1", 128'(cyc), 128'(GAP_CYCLES + 1));
        check("rr_gnt1", 128'(bus.gnt), 128'(2'b10));
        check("rr_cmd1", 128'(bus.send_cmd_content), 128'({CMD55, 32'h0}));
        tx(10);
        tick();
        check("rr_done1", 128'(bus.done), 128'(2'b10));
        wait_for("rr_send2", 0, GAP_CYCLES + 20, cyc);
        check("rr_spacing2", 128'(cyc), 128'(GAP_CYCLES + 1));
        check("rr_gnt2", 128'(bus.gnt), 128'(2'b01));
        tx(10);
        tick();
        check("rr_done2", 128'(bus.done), 128'(2'b01));
        bus.req = 2'b00;
        wait_for("rr_gnt_drop", 3, GAP_CYCLES + 10, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
